regfile_scoreboard: RTL and testbench

- Receiving end of the writeback interface: the integer register file that absorbs data_wb / RegWrite / RegDest from writeback and serves decode's two read ports.
- Keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards and stall.
- Sits between decode (read/issue side) and writeback (write/retire side) in the 5-stage RV32I pipeline.

---
 rtl/regfile_scoreboard_pkg.sv | 22 ++
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_scoreboard_sb_counter.sv | 48 ++++
 rtl/regfile_scoreboard.sv | 93 +++++++++
 tb/tb_regfile_scoreboard.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Purpose : shared constants and types for the integer register file / scoreboard slice.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package regfile_scoreboard_pkg;

    localparam int NREG      = 32;
    localparam int XLEN      = 32;
    localparam int CNT_W     = 2;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xdata_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    localparam reg_idx_t ZERO_REG = '0;

    // True when an enabled access targets idx and idx is a real (non-x0) register.
    function automatic logic idx_hit(input logic en, input reg_idx_t target, input reg_idx_t idx);
        return en && (target == idx) && (idx != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Purpose : decode read/issue, writeback and kill signals plus the regfile responses.
// Latency : n/a (wiring only); master = pipeline side, slave = register file.
// Backpressure: hazard is the only stall indication back to decode.
interface regfile_scoreboard_if;
    import regfile_scoreboard_pkg::*;

    reg_idx_t rs1_addr;
    reg_idx_t rs2_addr;
    xdata_t   rs1_data;
    xdata_t   rs2_data;
    logic     wb_RegWrite;
    reg_idx_t wb_RegDest;
    xdata_t   wb_data;
    logic     issue_valid;
    logic     issue_RegWrite;
    reg_idx_t issue_rd;
    logic     kill_valid;
    reg_idx_t kill_rd;
    logic     hazard;
    logic     sb_overflow;
    logic     sb_underflow;

    modport master (
        output rs1_addr, rs2_addr, wb_RegWrite, wb_RegDest, wb_data,
               issue_valid, issue_RegWrite, issue_rd, kill_valid, kill_rd,
        input  rs1_data, rs2_data, hazard, sb_overflow, sb_underflow
    );

    modport slave (
        input  rs1_addr, rs2_addr, wb_RegWrite, wb_RegDest, wb_data,
               issue_valid, issue_RegWrite, issue_rd, kill_valid, kill_rd,
        output rs1_data, rs2_data, hazard, sb_overflow, sb_underflow
    );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Purpose : one saturating pending-write counter (+1 issue, -0..2 retire/kill per cycle).
// Latency : count visible one cycle after the event; o_ovf/o_unf are same-cycle pulses.
// Backpressure: none; out-of-range results clamp and pulse a flag instead of stalling.
// Ports   : clk, rst (async high), i_inc, i_dec_count, o_cnt, o_ovf, o_unf.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic [1:0]       i_dec_count,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf,
    output logic             o_unf
);
    // Two extra bits hold the signed net result (range -2 .. max+1).
    localparam int W = CNT_W + 2;
    localparam logic signed [W-1:0] MAX_S = W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic signed [W-1:0]  w_net;
    logic [CNT_W-1:0]     w_next;

    always_comb begin
        w_net  = $signed({2'b00, r_cnt})
               + $signed({{(W-1){1'b0}}, i_inc})
               - $signed({{(W-2){1'b0}}, i_dec_count});
        o_unf  = w_net[W-1];
        o_ovf  = !o_unf && (w_net > MAX_S);
        w_next = w_net[CNT_W-1:0];
        if (o_ovf) begin
            w_next = '1;
        end else if (o_unf) begin
            w_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Purpose : RV32I integer register file with writeback bypass and per-register pending-write scoreboard.
// Latency : reads combinational (same-cycle wb bypass); writes and scoreboard updates land next cycle.
// Backpressure: hazard asserts while a read source has an unresolved pending write; decode stalls.
// Ports   : clk, rst (async high), bus (regfile_scoreboard_if.slave).
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);

    xdata_t     r_regs [NREG];
    logic       r_ovf;
    logic       r_unf;

    logic       w_wb_en;
    cnt_t       w_cnt  [NREG];
    logic [NREG-1:0] w_ovf;
    logic [NREG-1:0] w_unf;

    assign w_wb_en = bus.wb_RegWrite && (bus.wb_RegDest != ZERO_REG);

    // x0 is never written, so r_regs[0] stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[bus.wb_RegDest] <= bus.wb_data;
        end
    end

    function automatic xdata_t read_port(input reg_idx_t addr);
        if (addr == ZERO_REG) begin
            return '0;
        end else if (w_wb_en && (bus.wb_RegDest == addr)) begin
            return bus.wb_data;
        end
        return r_regs[addr];
    endfunction

    assign bus.rs1_data = read_port(bus.rs1_addr);
    assign bus.rs2_data = read_port(bus.rs2_addr);

    assign w_cnt[0] = '0;
    assign w_ovf[0] = 1'b0;
    assign w_unf[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_sb
        logic       w_inc;
        logic [1:0] w_dec;

        assign w_inc = bus.issue_valid && bus.issue_RegWrite && (bus.issue_rd == REG_IDX_W'(g));
        assign w_dec = {1'b0, idx_hit(bus.wb_RegWrite, bus.wb_RegDest, REG_IDX_W'(g))}
                     + {1'b0, idx_hit(bus.kill_valid,  bus.kill_rd,    REG_IDX_W'(g))};

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc),
            .i_dec_count (w_dec),
            .o_cnt       (w_cnt[g]),
            .o_ovf       (w_ovf[g]),
            .o_unf       (w_unf[g])
        );
    end

    // A writeback landing this cycle is covered by the bypass, so it retires one
    // pending write early. A zero count with a stray writeback reads as not pending.
    function automatic logic pending(input reg_idx_t addr);
        cnt_t wb_credit;
        wb_credit = cnt_t'(idx_hit(bus.wb_RegWrite, bus.wb_RegDest, addr));
        return (addr != ZERO_REG) && (w_cnt[addr] > wb_credit);
    endfunction

    assign bus.hazard = pending(bus.rs1_addr) || pending(bus.rs2_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf || (|w_ovf);
            r_unf <= r_unf || (|w_unf);
        end
    end

    assign bus.sb_overflow  = r_ovf;
    assign bus.sb_underflow = r_unf;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if bus();

    regfile_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  a1, a2;
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic        iv, iw;
        logic [4:0]  ird;
        logic        kv;
        logic [4:0]  krd;
    } stim_t;

    typedef struct {
        logic [31:0] rs1, rs2;
        logic        hz, ovf, unf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural values and integer pending counts.
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_ovf, m_unf;

    function automatic stim_t mk(input logic [4:0] a1, a2, input logic we, input logic [4:0] wd,
                                 input logic [31:0] wdat, input logic iv, iw, input logic [4:0] ird,
                                 input logic kv, input logic [4:0] krd);
        stim_t s;
        s.a1 = a1; s.a2 = a2; s.we = we; s.wd = wd; s.wdat = wdat;
        s.iv = iv; s.iw = iw; s.ird = ird; s.kv = kv; s.krd = krd;
        return s;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'h0;
            m_cnt[r]  = 0;
        end
        m_ovf = 0;
        m_unf = 0;
    endtask

    function automatic logic [31:0] m_read(input stim_t s, input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (s.we && s.wd == a) return s.wdat;
        return m_regs[a];
    endfunction

    function automatic bit m_pend(input stim_t s, input logic [4:0] a);
        int eff;
        if (a == 0) return 0;
        eff = m_cnt[a] - ((s.we && s.wd == a) ? 1 : 0);
        return eff > 0;
    endfunction

    function automatic exp_t m_expect(input stim_t s);
        exp_t e;
        e.rs1 = m_read(s, s.a1);
        e.rs2 = m_read(s, s.a2);
        e.hz  = m_pend(s, s.a1) || m_pend(s, s.a2);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    task automatic model_update(input stim_t s);
        int net;
        if (s.we && s.wd != 0) m_regs[s.wd] = s.wdat;
        for (int r = 1; r < 32; r++) begin
            net = m_cnt[r]
                + ((s.iv && s.iw && s.ird == r) ? 1 : 0)
                - ((s.we && s.wd == r) ? 1 : 0)
                - ((s.kv && s.krd == r) ? 1 : 0);
            if (net > 3) begin
                m_cnt[r] = 3;
                m_ovf = 1;
            end else if (net < 0) begin
                m_cnt[r] = 0;
                m_unf = 1;
            end else begin
                m_cnt[r] = net;
            end
        end
    endtask

    task automatic apply(input stim_t s);
        bus.rs1_addr = s.a1;       bus.rs2_addr = s.a2;
        bus.wb_RegWrite = s.we;    bus.wb_RegDest = s.wd;   bus.wb_data = s.wdat;
        bus.issue_valid = s.iv;    bus.issue_RegWrite = s.iw; bus.issue_rd = s.ird;
        bus.kill_valid = s.kv;     bus.kill_rd = s.krd;
    endtask

    // One pipeline cycle: drive, queue the expected response, advance the model at the edge.
    task automatic step(input stim_t s);
        apply(s);
        q.push_back(m_expect(s));
        @(posedge clk);
        model_update(s);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the register file answers every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rs1_data",     bus.rs1_data,     e.rs1);
            chk("rs2_data",     bus.rs2_data,     e.rs2);
            chk("hazard",       {31'h0, bus.hazard},       {31'h0, e.hz});
            chk("sb_overflow",  {31'h0, bus.sb_overflow},  {31'h0, e.ovf});
            chk("sb_underflow", {31'h0, bus.sb_underflow}, {31'h0, e.unf});
        end
    end

    // Asynchronous reset mid-run: outputs must clear before any clock edge.
    task automatic do_reset(input logic [4:0] a1, a2);
        apply(mk(a1, a2, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rs1_data", bus.rs1_data, 32'h0);
        chk("rst_rs2_data", bus.rs2_data, 32'h0);
        chk("rst_hazard",   {31'h0, bus.hazard},       32'h0);
        chk("rst_ovf",      {31'h0, bus.sb_overflow},  32'h0);
        chk("rst_unf",      {31'h0, bus.sb_underflow}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.a1   = 5'($urandom_range(0, 7));
        s.a2   = 5'($urandom_range(0, 7));
        s.we   = ($urandom_range(0, 99) < 40);
        s.wd   = 5'($urandom_range(0, 7));
        s.wdat = $urandom;
        s.iv   = ($urandom_range(0, 99) < 45);
        s.iw   = ($urandom_range(0, 99) < 80);
        s.ird  = 5'($urandom_range(0, 7));
        s.kv   = ($urandom_range(0, 99) < 10);
        s.krd  = 5'($urandom_range(0, 7));
        return s;
    endfunction

    initial begin
        model_reset();
        apply(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset then read.
        step(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Write with bypass, then from the array; x0 writes discarded.
        step(mk(7, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        step(mk(7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 7, 1, 0, 32'h1234, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // RAW stall on x3.
        step(mk(0, 0, 0, 0, 0, 1, 1, 3, 0, 0));
        step(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 3, 1, 3, 32'hA5A5_0003, 0, 0, 0, 0, 0));
        step(mk(3, 3, 0, 0, 0, 0, 0, 0, 0, 0));

        // Double pending on x4.
        step(mk(0, 0, 0, 0, 0, 1, 1, 4, 0, 0));
        step(mk(4, 0, 0, 0, 0, 1, 1, 4, 0, 0));
        step(mk(4, 0, 1, 4, 32'h4444_0001, 0, 0, 0, 0, 0));
        step(mk(4, 0, 1, 4, 32'h4444_0002, 0, 0, 0, 0, 0));
        step(mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Issue without RegWrite must not mark anything pending.
        step(mk(0, 0, 0, 0, 0, 1, 0, 6, 0, 0));
        step(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Simultaneous issue+wb, then kill on x9.
        step(mk(0, 0, 0, 0, 0, 1, 1, 9, 0, 0));
        step(mk(9, 0, 1, 9, 32'h9999_0009, 1, 1, 9, 0, 0));
        step(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 9, 0, 0, 0, 0, 0, 0, 1, 9));
        step(mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0));

        // Overflow on x10, underflow on x11, both sticky.
        for (int i = 0; i < 4; i++) step(mk(10, 0, 0, 0, 0, 1, 1, 10, 0, 0));
        step(mk(10, 11, 1, 11, 32'hBBBB_0011, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) step(mk(10, 11, 1, 10, 32'h1010_0000 + i, 0, 0, 0, 0, 0));
        step(mk(10, 11, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(10, 11, 0, 0, 0, 0, 0, 0, 0, 0));

        // wb and kill to the same index subtract two.
        step(mk(0, 0, 0, 0, 0, 1, 1, 12, 0, 0));
        step(mk(0, 0, 0, 0, 0, 1, 1, 12, 0, 0));
        step(mk(12, 0, 1, 12, 32'hC0DE_0012, 0, 0, 0, 1, 12));
        step(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        do_reset(7, 10);
        step(mk(7, 10, 0, 0, 0, 0, 0, 0, 0, 0));

        // Randomized traffic over a small index range to force collisions.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 500; i++) step(rand_stim());
            do_reset(5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)));
        end

        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
